// File: rtl/uart_alu_initiator.sv
// uart_alu_initiator: serializes one ALU command (header + operands) onto a
// byte-wide UART TX stream, then collects a 4-byte big-endian result from
// UART RX and presents it as a single 32-bit response word.
module uart_alu_initiator #(
  parameter int unsigned datawidth_p = 8,
  parameter int unsigned max_ops_p   = 4,
  parameter int unsigned timeout_p   = 65535
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [7:0]                       cmd_opcode_i,
  input  logic [$clog2(max_ops_p+1)-1:0]   cmd_nops_i,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic [31:0]                      opnd_data_i,
  input  logic                             opnd_valid_i,
  output logic                             opnd_ready_o,
  output logic [datawidth_p-1:0]           tx_data_o,
  output logic                             tx_valid_o,
  input  logic                             tx_ready_i,
  input  logic [datawidth_p-1:0]           rx_data_i,
  input  logic                             rx_valid_i,
  output logic                             rx_ready_o,
  output logic [31:0]                      rsp_data_o,
  output logic                             rsp_err_o,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i
);

  localparam int unsigned ops_w = $clog2(max_ops_p + 1);
  localparam int unsigned to_w  = $clog2(timeout_p + 1);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StOpLoad,
    StOpSend,
    StRxResp,
    StResp
  } state_t;

  state_t             state, state_n;
  logic [7:0]         opcode, opcode_n;
  logic [15:0]        len, len_n;
  logic [ops_w-1:0]   ops_left, ops_n;
  logic [1:0]         byte_cnt, bcnt_n;
  logic [31:0]        shift, shift_n;
  logic [to_w-1:0]    tcnt, tcnt_n, tcnt_inc;
  logic [31:0]        rsp_data_n;
  logic               rsp_err_n;
  logic [7:0]         tx_data_n;

  logic cmd_acc, opnd_acc, tx_acc, rx_acc, rsp_acc;

  assign cmd_acc  = cmd_valid_i  && cmd_ready_o;
  assign opnd_acc = opnd_valid_i && opnd_ready_o;
  assign tx_acc   = tx_valid_o   && tx_ready_i;
  assign rx_acc   = rx_valid_i   && rx_ready_o;
  assign rsp_acc  = rsp_valid_o  && rsp_ready_i;

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_n    = state;
    opcode_n   = opcode;
    len_n      = len;
    ops_n      = ops_left;
    bcnt_n     = byte_cnt;
    shift_n    = shift;
    tcnt_n     = tcnt;
    tcnt_inc   = (tcnt == '1) ? tcnt : tcnt + 1'b1;
    rsp_data_n = rsp_data_o;
    rsp_err_n  = rsp_err_o;
    tx_data_n  = '0;

    unique case (state)
      StIdle: begin
        if (cmd_acc) begin
          opcode_n   = cmd_opcode_i;
          len_n      = 16'd4 + (16'(cmd_nops_i) << 2);
          rsp_data_n = '0;
          rsp_err_n  = 1'b0;
          bcnt_n     = '0;
          if (32'(cmd_nops_i) > max_ops_p) begin
            state_n   = StResp;
            rsp_err_n = 1'b1;
          end else begin
            state_n = StHdr;
            ops_n   = cmd_nops_i;
          end
        end
      end

      StHdr: begin
        if (tx_acc) begin
          bcnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if (ops_left == '0) begin
              state_n = StRxResp;
              tcnt_n  = '0;
            end else begin
              state_n = StOpLoad;
            end
          end
        end
      end

      StOpLoad: begin
        if (opnd_acc) begin
          shift_n = opnd_data_i;
          bcnt_n  = '0;
          state_n = StOpSend;
        end
      end

      StOpSend: begin
        if (tx_acc) begin
          shift_n = {8'h00, shift[31:8]};
          bcnt_n  = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            ops_n = ops_left - 1'b1;
            if (ops_left == ops_w'(1)) begin
              state_n = StRxResp;
              tcnt_n  = '0;
            end else begin
              state_n = StOpLoad;
            end
          end
        end
      end

      StRxResp: begin
        if (rx_acc) begin
          rsp_data_n = {rsp_data_o[23:0], rx_data_i};
          tcnt_n     = '0;
          bcnt_n     = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state_n   = StResp;
            rsp_err_n = 1'b0;
          end
        end else begin
          tcnt_n = tcnt_inc;
          if (tcnt_inc == to_w'(timeout_p)) begin
            state_n    = StResp;
            rsp_data_n = '0;
            rsp_err_n  = 1'b1;
          end
        end
      end

      StResp: begin
        if (rsp_acc) state_n = StIdle;
      end

      default: state_n = StIdle;
    endcase

    // Outputs are registered from the next state, so the byte presented on
    // tx_data_o follows whichever byte the next cycle will offer.
    if (state_n == StHdr) begin
      unique case (bcnt_n)
        2'd0:    tx_data_n = opcode_n;
        2'd1:    tx_data_n = 8'h00;
        2'd2:    tx_data_n = len_n[7:0];
        default: tx_data_n = len_n[15:8];
      endcase
    end else if (state_n == StOpSend) begin
      tx_data_n = shift_n[7:0];
    end
  end

  // State, datapath and registered-output update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= StIdle;
      opcode       <= '0;
      len          <= '0;
      ops_left     <= '0;
      byte_cnt     <= '0;
      shift        <= '0;
      tcnt         <= '0;
      cmd_ready_o  <= 1'b1;
      opnd_ready_o <= 1'b0;
      tx_valid_o   <= 1'b0;
      tx_data_o    <= '0;
      rx_ready_o   <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      rsp_err_o    <= 1'b0;
    end else begin
      state        <= state_n;
      opcode       <= opcode_n;
      len          <= len_n;
      ops_left     <= ops_n;
      byte_cnt     <= bcnt_n;
      shift        <= shift_n;
      tcnt         <= tcnt_n;
      cmd_ready_o  <= (state_n == StIdle);
      opnd_ready_o <= (state_n == StOpLoad);
      tx_valid_o   <= (state_n == StHdr) || (state_n == StOpSend);
      tx_data_o    <= tx_data_n;
      rx_ready_o   <= (state_n == StRxResp);
      rsp_valid_o  <= (state_n == StResp);
      rsp_data_o   <= rsp_data_n;
      rsp_err_o    <= rsp_err_n;
    end
  end

endmodule

// File: tb/tb_uart_alu_initiator.sv
// Directed bench for uart_alu_initiator (max_ops_p=4, timeout_p=16).
module tb_uart_alu_initiator;

  logic        clk;
  logic        rst;
  logic [7:0]  cmd_opcode;
  logic [2:0]  cmd_nops;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] opnd_data;
  logic        opnd_valid;
  logic        opnd_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_valid;
  logic        rsp_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  tx_log[$];
  logic [31:0] ops_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] rsp_cap;
  logic        err_cap;
  int          stable_err;
  int          rx_ready_cycles;
  bit          got_rsp;

  uart_alu_initiator #(
    .datawidth_p(8),
    .max_ops_p  (4),
    .timeout_p  (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_opcode_i(cmd_opcode),
    .cmd_nops_i  (cmd_nops),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .opnd_data_i (opnd_data),
    .opnd_valid_i(opnd_valid),
    .opnd_ready_o(opnd_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one command from posedge+1 until the response is consumed.
  // Bytes/transfers are logged when valid&&ready holds for the coming edge.
  task automatic run_cmd(input logic [7:0] op, input logic [2:0] nops,
                         input bit gaps, input bit send_rx);
    int   cyc = 0;
    int   opi = 0;
    int   rxi = 0;
    bit   cmd_fire = 0;
    bit   held = 0;
    logic [7:0] last = '0;
    tx_log.delete();
    stable_err = 0;
    rx_ready_cycles = 0;
    got_rsp = 0;
    cmd_opcode = op;
    cmd_nops = nops;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    while (!got_rsp && cyc < 1000) begin
      if (cmd_fire) cmd_valid = 1'b0;
      cmd_fire = cmd_valid && cmd_ready;
      if (held && (!tx_valid || tx_data !== last)) stable_err++;
      tx_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      held = tx_valid && !tx_ready;
      last = tx_data;
      opnd_valid = (opi < ops_q.size()) && (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
      opnd_data = (opi < ops_q.size()) ? ops_q[opi] : 32'h0;
      if (opnd_valid && opnd_ready) opi++;
      rx_valid = send_rx && (rxi < rx_q.size());
      rx_data = (rxi < rx_q.size()) ? rx_q[rxi] : 8'h00;
      if (rx_valid && rx_ready) rxi++;
      if (rx_ready) rx_ready_cycles++;
      if (rsp_valid) begin
        got_rsp = 1;
        rsp_cap = rsp_data;
        err_cap = rsp_err;
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (!got_rsp) begin
      n_fail++;
      $display("FAIL rsp_timeout: got no response within %0d cycles, required one", cyc);
    end
    cmd_valid = 1'b0; opnd_valid = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 0; opnd_valid = 0; rx_valid = 0; tx_ready = 0; rsp_ready = 0;
    cmd_opcode = '0; cmd_nops = '0; opnd_data = '0; rx_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if ({tx_valid, tx_data, rx_ready, rsp_valid, rsp_data, rsp_err, opnd_ready, cmd_ready}
        !== {1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got tv=%b td=%h rr=%b rv=%b rd=%h re=%b or=%b cr=%b, required 0 00 0 0 0 0 0 1",
               tx_valid, tx_data, rx_ready, rsp_valid, rsp_data, rsp_err, opnd_ready, cmd_ready);
    end
  endtask

  task automatic test_add(input bit gaps);
    logic [7:0] exp_b[12] = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
                              8'h07, 8'h00, 8'h00, 8'h00};
    ops_q = '{32'h00000005, 32'h00000007};
    rx_q  = '{8'h00, 8'h00, 8'h00, 8'h0C};
    run_cmd(8'h10, 3'd2, gaps, 1'b1);
    n_checks++;
    if (tx_log.size() != 12) begin
      n_fail++;
      $display("FAIL add_tx_count(gaps=%0d): got %0d bytes, required 12", gaps, tx_log.size());
    end
    for (int i = 0; i < 12 && i < tx_log.size(); i++) begin
      n_checks++;
      if (tx_log[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL add_tx_byte%0d(gaps=%0d): got %h, required %h", i, gaps, tx_log[i], exp_b[i]);
      end
    end
    n_checks++;
    if (rsp_cap !== 32'h0000000C || err_cap !== 1'b0) begin
      n_fail++;
      $display("FAIL add_rsp(gaps=%0d): got %h err=%b, required 0000000c err=0", gaps, rsp_cap, err_cap);
    end
    n_checks++;
    if (stable_err != 0) begin
      n_fail++;
      $display("FAIL add_tx_stable(gaps=%0d): got %0d unstable stalls, required 0", gaps, stable_err);
    end
  endtask

  task automatic test_mul_noops();
    logic [7:0] exp_b[4] = '{8'h11, 8'h00, 8'h04, 8'h00};
    ops_q.delete();
    rx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_cmd(8'h11, 3'd0, 1'b0, 1'b1);
    n_checks++;
    if (tx_log.size() != 4) begin
      n_fail++;
      $display("FAIL mul_tx_count: got %0d bytes, required 4", tx_log.size());
    end
    for (int i = 0; i < 4 && i < tx_log.size(); i++) begin
      n_checks++;
      if (tx_log[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL mul_tx_byte%0d: got %h, required %h", i, tx_log[i], exp_b[i]);
      end
    end
    n_checks++;
    if (rsp_cap !== 32'hDEADBEEF || err_cap !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_rsp: got %h err=%b, required deadbeef err=0", rsp_cap, err_cap);
    end
  endtask

  task automatic test_timeout();
    ops_q.delete();
    rx_q.delete();
    run_cmd(8'h12, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (rx_ready_cycles != 16) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d idle rx cycles, required 16", rx_ready_cycles);
    end
    n_checks++;
    if (rsp_cap !== 32'h0 || err_cap !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_rsp: got %h err=%b, required 00000000 err=1", rsp_cap, err_cap);
    end
  endtask

  task automatic test_reject();
    int tv_seen = 0;
    cmd_opcode = 8'h10;
    cmd_nops = 3'd5;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reject_rsp: got v=%b err=%b data=%h, required v=1 err=1 data=00000000",
               rsp_valid, rsp_err, rsp_data);
    end
    for (int i = 0; i < 10; i++) begin
      if (tx_valid) tv_seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (tv_seen != 0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL reject_hold: got tx_valid cycles=%0d v=%b err=%b, required 0 1 1",
               tv_seen, rsp_valid, rsp_err);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_release: got cmd_ready=%b rsp_valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_operand();
    logic [7:0] exp_b[8] = '{8'h12, 8'h00, 8'h08, 8'h00, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    int  cnt = 0;
    bit  cmd_fire = 0;
    bit  reached = 0;
    cmd_opcode = 8'h11; cmd_nops = 3'd2; cmd_valid = 1'b1;
    opnd_valid = 1'b1; opnd_data = 32'h11223344; tx_ready = 1'b1;
    for (int c = 0; c < 100 && !reached; c++) begin
      if (cmd_fire) cmd_valid = 1'b0;
      cmd_fire = cmd_valid && cmd_ready;
      if (tx_valid && cnt == 5) reached = 1;
      else begin
        if (tx_valid) cnt++;
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL rst_mid_reach: got %0d bytes sent, required operand byte in flight", cnt);
    end
    cmd_valid = 1'b0; opnd_valid = 1'b0; tx_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_abort: got tx_valid=%b cmd_ready=%b, required 0 1", tx_valid, cmd_ready);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    ops_q = '{32'h0A0B0C0D};
    rx_q  = '{8'h00, 8'h00, 8'h00, 8'h02};
    run_cmd(8'h12, 3'd1, 1'b0, 1'b1);
    n_checks++;
    if (tx_log.size() != 8) begin
      n_fail++;
      $display("FAIL rst_next_count: got %0d bytes, required 8", tx_log.size());
    end
    for (int i = 0; i < 8 && i < tx_log.size(); i++) begin
      n_checks++;
      if (tx_log[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL rst_next_byte%0d: got %h, required %h", i, tx_log[i], exp_b[i]);
      end
    end
    n_checks++;
    if (rsp_cap !== 32'h00000002 || err_cap !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_next_rsp: got %h err=%b, required 00000002 err=0", rsp_cap, err_cap);
    end
  endtask

  initial begin
    test_reset();
    test_add(1'b0);
    test_add(1'b1);
    test_mul_noops();
    test_timeout();
    test_reject();
    test_reset_mid_operand();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
